// File: rtl/disp_demux_capture.sv
// Passive monitor for a multiplexed four-digit seven-segment bus.
// It rebuilds the four digit patterns from the active-low anode and
// segment lines. It also reports illegal strobes, completed frames and a
// bus that has gone quiet.
module disp_demux_capture #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [7:0] d0,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [7:0] d3,
  output logic [3:0] valid,
  output logic       frame_tick,
  output logic       err,
  output logic       stale
);

  localparam int              TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CNT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

  logic [3:0]    an_q, an_d;
  logic [7:0]    sseg_q, sseg_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [3:0]    seen_q, seen_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    dig_q [4];
  logic [7:0]    dig_d [4];
  logic [3:0]    valid_q, valid_d;
  logic          frame_tick_q, frame_tick_d;
  logic          err_q, err_d;
  logic          stale_q, stale_d;

  logic          sample_change;
  logic          accept;
  logic          accept_data;
  logic          one_low;
  logic          multi_low;
  logic          timeout;
  logic [3:0]    low;
  logic [3:0]    seen_base;
  logic [3:0]    write_mask;

  // Stability filter, strobe classification, frame and stale bookkeeping.
  always_comb begin
    an_d   = an;
    sseg_d = sseg;

    // The incoming sample is compared against the registered sample. A
    // segment-only change counts as a new sample.
    sample_change = ({an, sseg} != {an_q, sseg_q});
    accept        = (cnt_q == STABLE_MAX) && !done_q;

    low        = ~an_q;
    one_low    = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    multi_low  = (low != 4'd0) && !one_low;
    accept_data = accept && one_low;
    write_mask  = accept_data ? low : 4'd0;

    if (sample_change) begin
      cnt_d  = 8'd1;
      done_d = 1'b0;
    end else begin
      cnt_d  = (cnt_q >= STABLE_MAX) ? STABLE_MAX : cnt_q + 8'd1;
      done_d = done_q | accept;
    end

    for (int i = 0; i < 4; i++) begin
      dig_d[i] = write_mask[i] ? sseg_q : dig_q[i];
    end

    // If an acceptance lands on the timeout edge, the acceptance takes precedence.
    timeout = (timer_q == TIMER_LAST) && !accept_data;
    timer_d = (accept_data || timeout) ? '0 : timer_q + 1'b1;

    // A completed frame clears seen, but a digit accepted on the same edge survives.
    seen_base = (seen_q == 4'hF) ? 4'd0 : seen_q;
    if (timeout) begin
      seen_base = 4'd0;
    end
    seen_d = seen_base | write_mask;

    valid_d      = timeout ? 4'd0 : (valid_q | write_mask);
    frame_tick_d = (seen_q == 4'hF);
    err_d        = accept && multi_low;
    stale_d      = timeout;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q         <= 4'hF;
      sseg_q       <= 8'hFF;
      cnt_q        <= 8'd0;
      done_q       <= 1'b0;
      seen_q       <= 4'd0;
      timer_q      <= '0;
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= 8'hFF;
      end
      valid_q      <= 4'd0;
      frame_tick_q <= 1'b0;
      err_q        <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      seen_q       <= seen_d;
      timer_q      <= timer_d;
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= dig_d[i];
      end
      valid_q      <= valid_d;
      frame_tick_q <= frame_tick_d;
      err_q        <= err_d;
      stale_q      <= stale_d;
    end
  end

  assign d0         = dig_q[0];
  assign d1         = dig_q[1];
  assign d2         = dig_q[2];
  assign d3         = dig_q[3];
  assign valid      = valid_q;
  assign frame_tick = frame_tick_q;
  assign err        = err_q;
  assign stale      = stale_q;

endmodule
